// File: rtl/int_tx_pkg.sv
// rtl/int_tx_pkg.sv - shared state encodings, ASCII constants and widths for int_tx
package int_tx_pkg;

  localparam int DATA_W = 8;

  localparam logic [DATA_W-1:0] ASCII_ZERO  = 8'h30;
  localparam logic [DATA_W-1:0] ASCII_MINUS = 8'h2D;
  localparam logic [DATA_W-1:0] ASCII_CR    = 8'h0D;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CONV  = 3'd1,
    ST_SIGN  = 3'd2,
    ST_HUND  = 3'd3,
    ST_TENS  = 3'd4,
    ST_UNITS = 3'd5,
    ST_TERM  = 3'd6
  } tx_state_t;

endpackage

// File: rtl/int_tx_bin_to_bcd.sv
// rtl/int_tx_bin_to_bcd.sv - sequential shift-add-3 binary to BCD converter, 8-cycle latency
module bin_to_bcd
  import int_tx_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] bin,
  output logic              done,
  output logic [3:0]        hund,
  output logic [3:0]        tens,
  output logic [3:0]        units
);

  // {hundreds, tens, units, binary} working register
  logic [19:0] sh_q;
  logic [19:0] adj;
  logic [19:0] sh_step;
  logic [2:0]  cnt_q;
  logic        busy_q;

  // One double-dabble step: correct any BCD digit >= 5, then shift left
  always_comb begin
    adj = sh_q;
    if (adj[11:8]  >= 4'd5) adj[11:8]  = adj[11:8]  + 4'd3;
    if (adj[15:12] >= 4'd5) adj[15:12] = adj[15:12] + 4'd3;
    if (adj[19:16] >= 4'd5) adj[19:16] = adj[19:16] + 4'd3;
    sh_step = {adj[18:0], 1'b0};
  end

  // Load on start, then apply one step per cycle for eight cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_q   <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (start) begin
      sh_q   <= {12'd0, bin};
      cnt_q  <= '0;
      busy_q <= 1'b1;
    end else if (busy_q) begin
      sh_q  <= sh_step;
      cnt_q <= cnt_q + 3'd1;
      if (cnt_q == 3'd7) busy_q <= 1'b0;
    end
  end

  // done marks the cycle whose edge commits the final step
  assign done  = busy_q && (cnt_q == 3'd7);
  assign hund  = sh_q[19:16];
  assign tens  = sh_q[15:12];
  assign units = sh_q[11:8];

endmodule

// File: rtl/int_tx.sv
// rtl/int_tx.sv - sends a result byte as ASCII decimal plus terminator into a TX FIFO (INT_TX_SIGNED_EN: two's complement)
module int_tx
  import int_tx_pkg::*;
#(
  parameter logic [DATA_W-1:0] TERM = ASCII_CR
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              START,
  input  logic [DATA_W-1:0] RESULT,
  input  logic              FIFO_full,
  output logic [DATA_W-1:0] data_out,
  output logic              WR_FIFO,
  output logic              BUSY,
  output logic              DONE,
  output logic [2:0]        STATE
);

`ifdef INT_TX_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  tx_state_t         state_q, state_d;
  logic              neg_q;
  logic              done_q;
  logic              accept;
  logic [DATA_W-1:0] mag;
  logic              cvt_done;
  logic [3:0]        hund, tens, units;

  // 8'h80 negates to itself, which reads correctly as 128 unsigned
  assign mag = (SIGNED_EN && RESULT[7]) ? (8'd0 - RESULT) : RESULT;

  bin_to_bcd u_bcd (
    .clk   (CLK),
    .rst   (RESET),
    .start (accept),
    .bin   (mag),
    .done  (cvt_done),
    .hund  (hund),
    .tens  (tens),
    .units (units)
  );

  // Next-state and FIFO write decode; emitting states hold while the FIFO is full
  always_comb begin
    state_d  = state_q;
    data_out = '0;
    WR_FIFO  = 1'b0;
    accept   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // The DONE cycle is excluded so a back-to-back START is not taken
        if (START && !done_q) begin
          accept  = 1'b1;
          state_d = ST_CONV;
        end
      end
      ST_CONV: begin
        if (cvt_done) state_d = ST_SIGN;
      end
      ST_SIGN: begin
        if (SIGNED_EN && neg_q) begin
          data_out = ASCII_MINUS;
          WR_FIFO  = !FIFO_full;
          if (!FIFO_full) state_d = ST_HUND;
        end else begin
          state_d = ST_HUND;
        end
      end
      ST_HUND: begin
        if (hund != 4'd0) begin
          data_out = ASCII_ZERO + {4'd0, hund};
          WR_FIFO  = !FIFO_full;
          if (!FIFO_full) state_d = ST_TENS;
        end else begin
          state_d = ST_TENS;
        end
      end
      ST_TENS: begin
        if ((hund != 4'd0) || (tens != 4'd0)) begin
          data_out = ASCII_ZERO + {4'd0, tens};
          WR_FIFO  = !FIFO_full;
          if (!FIFO_full) state_d = ST_UNITS;
        end else begin
          state_d = ST_UNITS;
        end
      end
      ST_UNITS: begin
        data_out = ASCII_ZERO + {4'd0, units};
        WR_FIFO  = !FIFO_full;
        if (!FIFO_full) state_d = ST_TERM;
      end
      ST_TERM: begin
        data_out = TERM;
        WR_FIFO  = !FIFO_full;
        if (!FIFO_full) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, latched sign and the DONE pulse following the terminator write
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      neg_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_q == ST_TERM) && !FIFO_full;
      if (accept) neg_q <= SIGNED_EN && RESULT[7];
    end
  end

  assign BUSY  = (state_q != ST_IDLE);
  assign DONE  = done_q;
  assign STATE = state_q;

endmodule

// File: tb/tb_int_tx.sv
// tb/tb_int_tx.sv - scoreboard bench for int_tx: directed values, stall, reset abort, ignored STARTs
module tb_int_tx;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       START = 1'b0;
  logic [7:0] RESULT = 8'h00;
  logic       FIFO_full = 1'b0;
  logic [7:0] data_out;
  logic       WR_FIFO;
  logic       BUSY;
  logic       DONE;
  logic [2:0] STATE;

  int tests = 0;
  int fails = 0;
  logic [7:0] exp_q[$];

  int_tx dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .START     (START),
    .RESULT    (RESULT),
    .FIFO_full (FIFO_full),
    .data_out  (data_out),
    .WR_FIFO   (WR_FIFO),
    .BUSY      (BUSY),
    .DONE      (DONE),
    .STATE     (STATE)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    exp_q.push_back(b);
  endtask

  // Run one transfer; expected bytes must already be queued
  task automatic xfer(input logic [7:0] val, input bit restart, input bit stall);
    int   n;
    bit   busy_ok;
    bit   stalled;
    @(posedge CLK); #1;
    RESULT = val;
    START  = 1'b1;
    @(posedge CLK); #1;
    START  = 1'b0;
    RESULT = 8'hAA;
    busy_ok = 1'b1;
    stalled = 1'b0;
    n = 0;
    while (DONE !== 1'b1 && n < 100) begin
      if (BUSY !== 1'b1) busy_ok = 1'b0;
      if (restart && n == 3) begin START = 1'b1; RESULT = 8'd99; end
      if (restart && n == 4) START = 1'b0;
      if (stall && !stalled && STATE === 3'd5) begin
        stalled   = 1'b1;
        FIFO_full = 1'b1;
        repeat (5) begin
          @(posedge CLK); #1;
          check("stall_state", STATE, 3'd5);
          check("stall_data", data_out, 8'h37);
          check("stall_wr", WR_FIFO, 1'b0);
        end
        FIFO_full = 1'b0;
      end
      @(posedge CLK); #1;
      n++;
    end
    check("done_pulse", DONE, 1'b1);
    check("busy_held", busy_ok, 1'b1);
    check("busy_low_at_done", BUSY, 1'b0);
    check("queue_drained", exp_q.size(), 0);
    if (stall) check("stall_seen", stalled, 1'b1);
  endtask

  initial begin
    int n;
    fork
      forever begin
        @(negedge CLK);
        if (WR_FIFO === 1'b1) begin
          tests++;
          if (FIFO_full) begin
            fails++;
            $display("FAIL wr_while_full: data %0h", data_out);
          end else if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_write: got %0h expected none", data_out);
          end else begin
            logic [7:0] e;
            e = exp_q.pop_front();
            if (data_out !== e) begin
              fails++;
              $display("FAIL fifo_byte: got %0h expected %0h", data_out, e);
            end
          end
        end
      end
    join_none

    #1;
    check("rst_state", STATE, 3'd0);
    check("rst_data", data_out, 8'h00);
    check("rst_wr", WR_FIFO, 1'b0);
    check("rst_busy", BUSY, 1'b0);
    check("rst_done", DONE, 1'b0);
    repeat (2) @(posedge CLK);
    #1 RESET = 1'b0;

    push(8'h31); push(8'h30); push(8'h0D);
    xfer(8'd10, 1'b0, 1'b0);

    // START during the DONE cycle must not launch a transfer
    START = 1'b1; RESULT = 8'd5;
    @(posedge CLK); #1;
    START = 1'b0;
    check("start_at_done_state", STATE, 3'd0);
    check("start_at_done_busy", BUSY, 1'b0);

    push(8'h30); push(8'h0D);
    xfer(8'd0, 1'b0, 1'b0);

`ifdef INT_TX_SIGNED_EN
    push(8'h2D); push(8'h31); push(8'h0D);
    xfer(8'd255, 1'b0, 1'b0);
    push(8'h2D); push(8'h31); push(8'h30); push(8'h0D);
    xfer(8'hF6, 1'b0, 1'b0);
    push(8'h2D); push(8'h31); push(8'h32); push(8'h38); push(8'h0D);
    xfer(8'h80, 1'b0, 1'b0);
`else
    push(8'h32); push(8'h35); push(8'h35); push(8'h0D);
    xfer(8'd255, 1'b0, 1'b0);
    push(8'h32); push(8'h34); push(8'h36); push(8'h0D);
    xfer(8'hF6, 1'b0, 1'b0);
`endif

    push(8'h37); push(8'h0D);
    xfer(8'd7, 1'b0, 1'b1);

    push(8'h34); push(8'h32); push(8'h0D);
    xfer(8'd42, 1'b1, 1'b0);

    // Reset while in TENS of 123: only the hundreds digit may have gone out
    push(8'h31);
    @(posedge CLK); #1;
    RESULT = 8'd123; START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    n = 0;
    while (STATE !== 3'd3 && n < 50) begin
      @(posedge CLK); #1;
      n++;
    end
    check("reach_hund", STATE, 3'd3);
    @(posedge CLK); #1;
    check("reach_tens", STATE, 3'd4);
    RESET = 1'b1;
    #1;
    check("abort_state", STATE, 3'd0);
    check("abort_data", data_out, 8'h00);
    check("abort_wr", WR_FIFO, 1'b0);
    check("abort_busy", BUSY, 1'b0);
    check("abort_done", DONE, 1'b0);
    repeat (2) @(posedge CLK);
    #1 RESET = 1'b0;
    repeat (20) @(posedge CLK);
    #1;
    check("abort_idle", STATE, 3'd0);
    check("abort_queue", exp_q.size(), 0);

    push(8'h39); push(8'h0D);
    xfer(8'd9, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/int_tx.md
INT_TX -- requirements
Module: int_tx

Interface
REQ-001 SHALL have parameter: TERM  8'h0D  terminator byte appended after every number.
REQ-002 SHALL have port: CLK  input  1  system clock, all state updates on rising edge.
REQ-003 SHALL have port: RESET  input  1  asynchronous active-high reset.
REQ-004 SHALL have port: START  input  1  request to transmit RESULT, sampled in IDLE only.
REQ-005 SHALL have port: RESULT  input  8  ALU result to be sent as ASCII decimal.
REQ-006 SHALL have port: FIFO_full  input  1  TX FIFO full flag; no write while high.
REQ-007 SHALL have port: data_out  output  8  ASCII byte presented to the TX FIFO w_data.
REQ-008 SHALL have port: WR_FIFO  output  1  one-cycle write strobe to the TX FIFO.
REQ-009 SHALL have port: BUSY  output  1  high from START acceptance until DONE.
REQ-010 SHALL have port: DONE  output  1  one-cycle pulse after the terminator write.
REQ-011 SHALL have port: STATE  output  3  current FSM state encoding, for debug.

Function
REQ-012 SHALL implement the FSM: IDLE=0, CONV=1, SIGN=2, HUND=3, TENS=4, UNITS=5, TERM=6.
REQ-013 IDLE: on START=1, SHALL latch RESULT, set BUSY=1 and enter CONV next cycle.
REQ-014 CONV SHALL run a shift-add-3 binary-to-BCD conversion for exactly 8 cycles, then enter SIGN.
REQ-015 SIGN SHALL pass straight to HUND without writing when INT_TX_SIGNED_EN is undefined.
REQ-016 HUND SHALL emit 8'h30+hundreds unless hundreds=0; a zero digit is skipped in 1 cycle with no write.
REQ-017 TENS SHALL emit 8'h30+tens unless hundreds=0 and tens=0, in which case it skips in 1 cycle.
REQ-018 UNITS SHALL always emit 8'h30+units, so a value of 0 is sent as "0".
REQ-019 TERM SHALL emit the TERM byte, then return to IDLE with BUSY=0 and DONE=1 for one cycle.
REQ-020 Each emitting state SHALL assert WR_FIFO for exactly one cycle, with data_out valid in the same cycle, only when FIFO_full=0.
REQ-021 While FIFO_full=1 in an emitting state, the block SHALL hold its state and data_out with WR_FIFO=0 (stall, no loss, no duplicate).
REQ-022 START while BUSY=1 SHALL be ignored; RESULT changes after latching SHALL have no effect.
REQ-023 START and DONE in the same cycle SHALL NOT start a new transfer; START must be seen in IDLE.

Reset
REQ-024 RESET=1 SHALL force STATE=IDLE, data_out=8'h00, WR_FIFO=0, BUSY=0, DONE=0, and clear the latched value and BCD registers, at any time.
REQ-025 A reset mid-transfer SHALL abort it; no further WR_FIFO pulses until the next START after reset release.

Configuration
REQ-026 With macro INT_TX_SIGNED_EN defined, RESULT SHALL be treated as two's complement.
- CONV converts the magnitude.
- SIGN emits '-' (8'h2D) first when RESULT[7]=1; the magnitude of 8'h80 is 128.
REQ-027 Without INT_TX_SIGNED_EN, RESULT SHALL be unsigned 0..255 and SIGN never writes.

Structure
REQ-028 A shared package SHALL hold the state encodings, ASCII constants (zero 8'h30, minus 8'h2D, CR 8'h0D) and the data width 8.
REQ-029 The BCD converter SHALL be a separate sub-module, bin_to_bcd, with start/done handshake and 8-cycle latency.

Verification
REQ-030 SHALL check: RESULT=10, START pulse, FIFO never full -> writes 8'h31, 8'h30, 8'h0D, then a DONE pulse; BUSY high for the whole transfer.
REQ-031 SHALL check: RESULT=0 -> writes 8'h30, 8'h0D only; RESULT=255 -> writes 8'h32, 8'h35, 8'h35, 8'h0D.
REQ-032 SHALL check: RESULT=7, FIFO_full held high 5 cycles at UNITS -> no write during the stall, then exactly one 8'h37 followed by 8'h0D.
REQ-033 SHALL check: RESET asserted during TENS for RESULT=123 -> outputs go to reset values immediately and no writes follow.
REQ-034 SHALL check: a second START during BUSY -> ignored; only the first value is transmitted.
REQ-035 SHALL check, with INT_TX_SIGNED_EN defined: RESULT=8'hF6 -> 8'h2D, 8'h31, 8'h30, 8'h0D; RESULT=8'h80 -> 8'h2D, 8'h31, 8'h32, 8'h38, 8'h0D.
